aes_round_iter: RTL

- Iterative AES cipher datapath: one round per clock, reusing a single subbytes/shiftrows/mixcolumn slice.
- Generalises the fixed combinational round to a parametrised round count covering AES-128, AES-192 and AES-256, given an externally expanded key schedule.
- Adds a valid/ready handshake on both sides.
- Sits between the key-expansion block and the top-level cipher wrapper.

---
 rtl/aes_round_iter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/aes_round_iter.sv
// aes_round_iter: iterative AES encryption core, one cipher round per clock on a single round slice.
// Latency: out_valid rises NR edges after the accept edge; one block every NR+1 cycles when unstalled.
// Backpressure: the result is held in DONE until out_ready; in_ready is low while a block is in flight.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   in_valid/in_ready         input handshake for data_in + round_keys
//   data_in[127:0]            plaintext, bits [127:120] are byte 0
//   round_keys                NR+1 expanded keys, key i at [128*i +: 128], key 0 is the whitening key
//   out_valid/out_ready       output handshake for data_out
//   data_out[127:0]           ciphertext, same byte order as data_in
//   busy                      high whenever the core is not IDLE
module aes_round_iter #(
    parameter int NR = 10,
    parameter int CW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          data_in,
    input  logic [128*(NR+1)-1:0] round_keys,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          data_out,
    output logic                  busy
);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_round_iter: NR must be 10, 12 or 14");
    end
    if ((1 << CW) <= NR) begin : g_bad_cw
        $error("aes_round_iter: CW too narrow to count to NR");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed rather than tabulated: the inverse is a^254 (a^2 * a^4 * ... * a^128),
    // which also maps 0 to 0, followed by the standard affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // SubBytes + ShiftRows, plus MixColumns unless this is the final round.
    // Byte n of the state sits at bits [127-8n -: 8]; row = n%4, column = n/4.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic final_round);
        logic [7:0]   b [16];
        logic [7:0]   r [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int n = 0; n < 16; n++) b[n] = sbox(s[127-8*n -: 8]);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[w+4*c] = b[w + 4*((c + w) % 4)];
        if (!final_round) begin
            for (int c = 0; c < 4; c++) begin
                a0 = r[4*c];
                a1 = r[4*c+1];
                a2 = r[4*c+2];
                a3 = r[4*c+3];
                r[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                r[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                r[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                r[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        o = '0;
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = r[n];
        return o;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [127:0]   st_reg;
    logic [127:0]   key_reg [NR+1];
    logic           accept;
    logic           last_round;
    logic [127:0]   round_out;

    // DONE with out_ready lets the next block in on the same edge the result leaves.
    assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
    assign accept     = in_valid && in_ready;
    assign last_round = (cnt == CW'(NR));
    assign round_out  = aes_round(st_reg, last_round) ^ key_reg[cnt];

    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign data_out   = st_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            st_reg <= '0;
            for (int i = 0; i <= NR; i++) key_reg[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        // Whole schedule is captured so the source is free after the accept.
                        st_reg <= data_in ^ round_keys[127:0];
                        for (int i = 0; i <= NR; i++) key_reg[i] <= round_keys[128*i +: 128];
                        cnt    <= CW'(1);
                        state  <= RUN;
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    st_reg <= round_out;
                    if (last_round) state <= DONE;
                    else            cnt   <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
